mem_burst_ctrl: RTL and testbench

//  Main-memory burst controller and backing store, directly downstream of the L2 cache.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_array.sv | 27 ++
 rtl/mem_burst_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_burst_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory burst controller.
// Optional feature macro used by mem_burst_ctrl: MEM_CWF_EN (critical-word-first beat order).
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        BEAT0,
        BEAT1,
        DONE
    } state_t;

    // Direction as encoded on the active-low we_MEM pin.
    localparam logic DATA_BUS_READ  = 1'b1;
    localparam logic DATA_BUS_WRITE = 1'b0;

    function automatic int beat_idx_width(input int burst_length);
        return (burst_length > 1) ? $clog2(burst_length) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port backing RAM: one read or one write per enabled cycle.
// Read data is registered and holds its value until the next enabled read.
module mem_array #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Main-memory burst controller for L2 fills and writebacks over a shared tri-state bus.
// Define MEM_CWF_EN to start each burst at the requested word (critical-word-first).
module mem_burst_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int BURST_LENGTH   = 2,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int ACCESS_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we_MEM,
    input  logic [ADDR_WIDTH-1:0] addr_MEM,
    inout  wire logic [DATA_WIDTH-1:0] data_MEM,
    output logic                  stb,
    output logic                  busy,
    output logic                  done
);

    localparam int BEAT_W = beat_idx_width(BURST_LENGTH);
    localparam int LAT_W  = $clog2(ACCESS_LATENCY + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LENGTH - 1);
    // The beat-0 access occupies the last latency cycle, so WAIT itself lasts L-1 cycles.
    localparam logic [LAT_W-1:0] LAT_LAST =
        LAT_W'((ACCESS_LATENCY > 1) ? ACCESS_LATENCY - 2 : 0);
    localparam logic [MEM_DEPTH_LOG2-1:0] OFF_MASK = MEM_DEPTH_LOG2'(BURST_LENGTH - 1);

    state_t state, state_nxt;

    logic                      dir;
    logic [MEM_DEPTH_LOG2-1:0] word_idx;
    logic [LAT_W-1:0]          lat_cnt;
    logic [BEAT_W-1:0]         beat_cnt;
    logic                      drive_en;
    logic                      accept;
    logic                      ram_en;
    logic                      ram_we;
    logic [MEM_DEPTH_LOG2-1:0] crit_off;
    logic [MEM_DEPTH_LOG2-1:0] beat_off;
    logic [MEM_DEPTH_LOG2-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]     ram_rdata;

    wire unused_addr_bits = ^{addr_MEM[2:0], addr_MEM[ADDR_WIDTH-1:3+MEM_DEPTH_LOG2]};

`ifdef MEM_CWF_EN
    assign crit_off = word_idx & OFF_MASK;
`else
    assign crit_off = '0;
`endif

    assign beat_off = (MEM_DEPTH_LOG2'(beat_cnt) + crit_off) & OFF_MASK;
    assign ram_addr = (word_idx & ~OFF_MASK) | beat_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req && !busy) begin
                    accept    = 1'b1;
                    state_nxt = (ACCESS_LATENCY > 1) ? WAIT : BEAT0;
                end
            end
            WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_nxt = BEAT0;
                end
            end
            BEAT0: begin
                ram_en    = !rst;
                ram_we    = (dir == DATA_BUS_WRITE);
                state_nxt = BEAT1;
            end
            BEAT1: begin
                state_nxt = (beat_cnt == BEAT_LAST) ? DONE : BEAT0;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stb      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            drive_en <= 1'b0;
            lat_cnt  <= '0;
            beat_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy     <= 1'b1;
                        dir      <= we_MEM;
                        word_idx <= addr_MEM[3 +: MEM_DEPTH_LOG2];
                        lat_cnt  <= '0;
                        beat_cnt <= '0;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt + LAT_W'(1);
                end
                BEAT0: begin
                    if (dir == DATA_BUS_READ) begin
                        drive_en <= 1'b1;
                    end
                end
                BEAT1: begin
                    stb      <= ~stb;
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
                DONE: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    drive_en <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // The RAM's registered read port doubles as the bus drive register.
    mem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_LOG2(MEM_DEPTH_LOG2)
    ) u_mem_array (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(data_MEM),
        .rdata(ram_rdata)
    );

    assign data_MEM = drive_en ? ram_rdata : 'z;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: scoreboarded read beats, write/readback,
// burst ordering, request-while-busy and mid-burst reset.
module tb_mem_burst_ctrl;

    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int BL  = 2;
    localparam int DL  = 10;
    localparam int LAT = 4;
    localparam logic [DW-1:0] PROBE = 64'h5A5A_5A5A_A5A5_A5A5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we_mem;
    logic [AW-1:0] addr;
    wire  [DW-1:0] data_bus;
    logic          stb;
    logic          busy;
    logic          done;

    logic          tb_drive;
    logic [DW-1:0] tb_data;

    int            err_cnt  = 0;
    int            chk_cnt  = 0;
    int            cyc      = 0;
    int            done_cnt = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] model [int];
    bit            mon_read = 1'b0;
    logic          mon_stb  = 1'b0;

    assign data_bus = tb_drive ? tb_data : 'z;

    mem_burst_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .BURST_LENGTH  (BL),
        .MEM_DEPTH_LOG2(DL),
        .ACCESS_LATENCY(LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .we_MEM  (we_mem),
        .addr_MEM(addr),
        .data_MEM(data_bus),
        .stb     (stb),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Word touched by beat k of a burst, derived independently from the address map.
    function automatic int beat_word(input logic [AW-1:0] a, input int k);
        int idx;
        int off;
        idx = int'(a[3 +: DL]);
`ifdef MEM_CWF_EN
        off = idx % BL;
`else
        off = 0;
`endif
        return (idx - (idx % BL)) + ((off + k) % BL);
    endfunction

    // Each stb edge during a read is checked against the next expected beat.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (stb !== mon_stb) begin
            mon_stb = stb;
            if (mon_read) begin
                if (exp_q.size() > 0) checkOutput("sb_beat", data_bus, exp_q.pop_front());
                else checkOutput("sb_extra_beat", 64'(exp_q.size()), 64'd1);
            end
        end
    end

    task automatic check_released(input string tag);
        tb_data  = PROBE;
        tb_drive = 1'b1;
        #1;
        checkOutput(tag, data_bus, PROBE);
        tb_drive = 1'b0;
        #1;
    endtask

    task automatic applyStimulus(input bit is_write, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        logic [DW-1:0] beats [BL];
        int   t0;
        int   k;
        int   rel;
        logic seen_stb;
        bit   got_done;
        beats[0] = d0;
        beats[1] = d1;
        for (int i = 0; i < BL; i++) begin
            if (is_write) model[beat_word(a, i)] = beats[i];
            else exp_q.push_back(model[beat_word(a, i)]);
        end
        mon_read = !is_write;
        @(negedge clk);
        req    = 1'b1;
        we_mem = !is_write;
        addr   = a;
        if (is_write) begin
            tb_data  = beats[0];
            tb_drive = 1'b1;
        end
        @(posedge clk); #1;
        t0  = cyc;
        req = 1'b0;
        checkOutput("accept_busy", 64'(busy), 64'd1);
        seen_stb = stb;
        k        = 0;
        got_done = 1'b0;
        for (int c = 0; c < 64 && !got_done; c++) begin
            @(posedge clk); #1;
            rel = cyc - t0;
            if (stb !== seen_stb) begin
                seen_stb = stb;
                checkOutput("stb_time", 64'(rel), 64'(LAT + 2 * k + 1));
                k++;
                if (is_write && k < BL) tb_data = beats[k];
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                checkOutput("done_time", 64'(rel), 64'(LAT + 2 * BL));
                checkOutput("done_busy_low", 64'(busy), 64'd0);
            end
        end
        tb_drive = 1'b0;
        checkOutput("done_seen", 64'(got_done), 64'd1);
        checkOutput("beat_count", 64'(k), 64'(BL));
        check_released("bus_released");
        @(posedge clk); #1;
        checkOutput("done_one_cycle", 64'(done), 64'd0);
        @(negedge clk); #1;
        mon_read = 1'b0;
        checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int   t0;
        int   rel;
        int   dcount0;
        bit   got_done;
        logic seen_stb;
        bit   toggled;

        rst      = 1'b1;
        req      = 1'b0;
        we_mem   = 1'b1;
        addr     = '0;
        tb_drive = 1'b0;
        tb_data  = '0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("reset_stb", 64'(stb), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        check_released("reset_bus_released");

        // Preload words 0..1, then read them back with timing checks
        applyStimulus(1'b1, 32'h0, 64'h1111_1111_0000_0000, 64'h3333_3333_2222_2222);
        applyStimulus(1'b0, 32'h0, '0, '0);

        // Writeback and readback
        applyStimulus(1'b1, 32'h10, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB);
        applyStimulus(1'b0, 32'h10, '0, '0);

        // Odd word address: order depends on critical-word-first
        applyStimulus(1'b0, 32'h8, '0, '0);

        // Odd-offset writeback, then reads through the aligned and wrapped addresses
        applyStimulus(1'b1, 32'h18, 64'hCCCC_CCCC_1234_5678, 64'hDDDD_DDDD_8765_4321);
        applyStimulus(1'b0, 32'h10, '0, '0);
        applyStimulus(1'b0, 32'h0000_2010, '0, '0);

        // req held for a whole burst: one transfer, then re-accept right after done
        dcount0 = done_cnt;
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < BL; i++) exp_q.push_back(model[beat_word(32'h10, i)]);
        mon_read = 1'b1;
        @(negedge clk);
        req    = 1'b1;
        we_mem = 1'b1;
        addr   = 32'h10;
        @(posedge clk); #1;
        t0       = cyc;
        got_done = 1'b0;
        for (int c = 0; c < 64 && !got_done; c++) begin
            @(posedge clk); #1;
            rel = cyc - t0;
            if (done === 1'b1) begin
                got_done = 1'b1;
                checkOutput("hold_done_time", 64'(rel), 64'(LAT + 2 * BL));
            end
        end
        checkOutput("hold_done_seen", 64'(got_done), 64'd1);
        @(posedge clk); #1;
        checkOutput("hold_reaccept_busy", 64'(busy), 64'd1);
        checkOutput("hold_done_pulse", 64'(done), 64'd0);
        t0       = cyc;
        req      = 1'b0;
        got_done = 1'b0;
        for (int c = 0; c < 64 && !got_done; c++) begin
            @(posedge clk); #1;
            rel = cyc - t0;
            if (done === 1'b1) begin
                got_done = 1'b1;
                checkOutput("hold2_done_time", 64'(rel), 64'(LAT + 2 * BL));
            end
        end
        checkOutput("hold2_done_seen", 64'(got_done), 64'd1);
        @(negedge clk); #1;
        mon_read = 1'b0;
        checkOutput("hold_done_count", 64'(done_cnt - dcount0), 64'd2);
        checkOutput("hold_sb_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Reset right after the first stb toggle of a read
        dcount0 = done_cnt;
        @(negedge clk);
        req    = 1'b1;
        we_mem = 1'b1;
        addr   = 32'h0;
        @(posedge clk); #1;
        t0       = cyc;
        req      = 1'b0;
        seen_stb = stb;
        toggled  = 1'b0;
        rel      = 0;
        for (int c = 0; c < 64 && !toggled; c++) begin
            @(posedge clk); #1;
            rel = cyc - t0;
            if (stb !== seen_stb) toggled = 1'b1;
        end
        checkOutput("rst_first_toggle", 64'(rel), 64'(LAT + 1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_stb", 64'(stb), 64'd0);
        check_released("rst_bus_released");
        repeat (LAT + 2 * BL + 2) @(posedge clk);
        #1;
        checkOutput("rst_stays_idle", 64'(busy), 64'd0);
        @(negedge clk); #1;
        checkOutput("rst_no_done", 64'(done_cnt - dcount0), 64'd0);
        applyStimulus(1'b0, 32'h0, '0, '0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
